dmem_dma_arbiter: RTL and testbench
===================================

Name: dmem_dma_arbiter

Overview:
- Shares the single-port data memory between the single-cycle CPU and a UART receive DMA engine.
- CPU accesses always win and pass through with zero latency, because the core cannot stall.
- UART bytes are packed little-endian into 32-bit words, buffered in a small FIFO, and written to a configured memory window in cycles the CPU leaves idle.
- Sits between the core's load/store signals and DataMem; raises a done interrupt toward Peripheral.

Parameters:
FIFO_DEPTH, 4, word FIFO entries (power of 2, >=2)
LEN_W, 16, width of transfer length and word pointer

Ports:
clk  in  1  system clock (divided CPU clock)
reset  in  1  asynchronous, active-low reset
cpu_rd  in  1  CPU load strobe
cpu_wr  in  1  CPU store strobe
cpu_addr  in  32  CPU byte address (ALU result)
cpu_wdata  in  32  CPU store data
rx_valid  in  1  one-cycle pulse, UART byte available
rx_byte  in  8  received byte
cfg_we  in  1  one-cycle pulse: load config and (re)arm
cfg_base  in  32  destination byte address; bits [1:0] forced to 0
cfg_len  in  LEN_W  transfer length in words
mem_rd  out  1  to DataMem
mem_wr  out  1  to DataMem
mem_addr  out  32  to DataMem
mem_wdata  out  32  to DataMem
busy  out  1  state is ACTIVE or DRAIN
done  out  1  sticky, state is DONE
ovf  out  1  sticky, a packed word was dropped
irq  out  1  one-cycle pulse on entry to DONE
words_done  out  LEN_W  words written to memory

Behaviour:
- Reset (async, reset==0): state IDLE; FIFO empty; byte count, pointers, words_done, ovf, done, irq all 0. mem_* reset to 0 via their combinational inputs.
- CPU request: cpu_req = (cpu_rd | cpu_wr) & ~cpu_addr[30]. Peripheral-space accesses are not memory requests.
- Mux (combinational, same cycle):
  - If cpu_req: mem_rd=cpu_rd, mem_wr=cpu_wr, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - Else if state in {ACTIVE, DRAIN} and FIFO not empty: DMA grant. mem_wr=1, mem_rd=0, mem_addr=base+{wr_ptr,2'b00} (mod 2^32), mem_wdata=FIFO head.
  - Otherwise all mem_* are 0.
- Pop on DMA grant; words_done increments on the same clock edge.
- Packing (ACTIVE only):
  - Byte k (k=0..3) goes to bits [8k+7:8k].
  - The 4th byte completes a word. Push if FIFO not full, or if full with a pop in the same cycle. Otherwise drop the word and set ovf.
  - words_rcvd increments on completion whether or not the word was dropped.
- FSM:
  - IDLE: cfg_we & cfg_len!=0 -> ACTIVE. cfg_we & cfg_len==0 -> DONE with irq pulse.
  - ACTIVE: words_rcvd==len -> DRAIN. Bytes arriving in the same cycle as the final completion are ignored.
  - DRAIN: ignore rx; FIFO empty -> DONE with irq pulse.
  - DONE: done=1; cfg_we -> behaves as from IDLE.
- cfg_we in any state aborts and re-arms:
  - flush FIFO, clear partial byte count, words_rcvd, words_done, ovf;
  - latch base and len;
  - a DMA write granted in that same cycle still completes to memory but is not counted.
- rx_valid in IDLE/DONE is ignored.
- CPU issuing a request every cycle starves DMA indefinitely; this is permitted and exercises FIFO overflow.

Optional Feature:
DMEM_DMA_CSUM_EN
- Defined: adds output csum [31:0], the mod-2^32 sum of every word written by DMA grants. Cleared on reset and cfg_we; stable in DONE.
- Undefined: port and accumulator absent.

Decomposition:
- Shared package: FSM state encoding (IDLE=0, ACTIVE=1, DRAIN=2, DONE=3); peripheral-space address bit index (30).
- One natural sub-module: dma_word_fifo, a synchronous FIFO with push/pop/full/empty, simultaneous push+pop allowed when full.

Test Plan:
- Idle CPU, cfg base=0x100 len=2, bytes 11 22 33 44 55 66 77 88 -> writes 0x44332211@0x100 and 0x88776655@0x104; irq pulses once; done=1; words_done=2.
- CPU cpu_rd to 0x200 in every cycle a word is pending -> mem_addr=0x200 with zero latency; DMA write occurs the first cycle cpu_req=0.
- CPU store to 0x40000010 (peripheral) while a word is pending -> DMA write granted that cycle.
- CPU busy continuously, len=8, 24 bytes (6 words) -> 4 queued, 2 dropped, ovf=1; after CPU idles, DMA stays in ACTIVE until 8 words received.
- cfg_we mid-transfer with 2 bytes partial -> FIFO flushed, counters 0, new base used, done/ovf cleared.
- cfg_len=0 -> immediate DONE, irq pulse, no memory writes; async reset mid-DRAIN -> IDLE, all outputs 0.

Source files
------------

// File: rtl/dmem_dma_arbiter_pkg.sv
// Shared definitions for the CPU / UART-DMA data memory arbiter.
package dmem_dma_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StActive = 2'd1;
  localparam state_t StDrain  = 2'd2;
  localparam state_t StDone   = 2'd3;

  // Addresses with this bit set belong to peripheral space, not DataMem.
  localparam int unsigned PeriphBit = 30;

  function automatic logic is_mem_req(logic rd, logic wr, logic [31:0] addr);
    return (rd | wr) & ~addr[PeriphBit];
  endfunction

endpackage

// File: rtl/dmem_dma_arbiter_if.sv
// Load/store bus bundle used for both the CPU side and the DataMem side.
interface dmem_dma_arbiter_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;

  modport master (output rd, wr, addr, wdata);
  modport slave  (input  rd, wr, addr, wdata);
endinterface

// File: rtl/dmem_dma_arbiter_dma_word_fifo.sv
// Synchronous word FIFO; a push while full is accepted when a pop happens in the same cycle.
module dmem_dma_arbiter_dma_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/dmem_dma_arbiter.sv
// Data memory arbiter: CPU passes through, UART bytes are packed and written by DMA in idle cycles.
// Optional DMEM_DMA_CSUM_EN adds csum_o, the running sum of all DMA-written words.
module dmem_dma_arbiter
  import dmem_dma_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  dmem_dma_arbiter_if.slave  cpu_bus,
  dmem_dma_arbiter_if.master mem_bus,
  input  logic               rx_valid_i,
  input  logic [7:0]         rx_byte_i,
  input  logic               cfg_we_i,
  input  logic [31:0]        cfg_base_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               ovf_o,
  output logic               irq_o,
  output logic [LEN_W-1:0]   words_done_o
`ifdef DMEM_DMA_CSUM_EN
  ,
  output logic [31:0]        csum_o
`endif
);

  state_t           state_q, state_d;
  logic [31:0]      base_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] words_rcvd_q, words_rcvd_d;
  logic [LEN_W-1:0] words_done_q, words_done_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [23:0]      part_q, part_d;
  logic             ovf_q, ovf_d;
  logic             irq_q, irq_d;

  logic             cpu_req, dma_active, dma_grant;
  logic             rx_take, word_cmpl, push;
  logic             fifo_full, fifo_empty;
  logic [31:0]      fifo_head, dma_addr;

  assign cpu_req    = is_mem_req(cpu_bus.rd, cpu_bus.wr, cpu_bus.addr);
  assign dma_active = (state_q == StActive) || (state_q == StDrain);
  assign dma_grant  = ~cpu_req & dma_active & ~fifo_empty;
  assign dma_addr   = base_q + 32'({words_done_q, 2'b00});

  // Once the last word has been counted, further bytes are ignored until re-armed.
  assign rx_take   = rx_valid_i & (state_q == StActive) & (words_rcvd_q != len_q) & ~cfg_we_i;
  assign word_cmpl = rx_take & (byte_cnt_q == 2'd3);
  assign push      = word_cmpl & (~fifo_full | dma_grant);

  dmem_dma_arbiter_dma_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (cfg_we_i),
    .push_i  (push),
    .wdata_i ({rx_byte_i, part_q}),
    .pop_i   (dma_grant),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    mem_bus.rd    = 1'b0;
    mem_bus.wr    = 1'b0;
    mem_bus.addr  = '0;
    mem_bus.wdata = '0;
    if (cpu_req) begin
      mem_bus.rd    = cpu_bus.rd;
      mem_bus.wr    = cpu_bus.wr;
      mem_bus.addr  = cpu_bus.addr;
      mem_bus.wdata = cpu_bus.wdata;
    end else if (dma_grant) begin
      mem_bus.wr    = 1'b1;
      mem_bus.addr  = dma_addr;
      mem_bus.wdata = fifo_head;
    end
  end

  always_comb begin
    state_d      = state_q;
    words_rcvd_d = words_rcvd_q;
    words_done_d = words_done_q;
    byte_cnt_d   = byte_cnt_q;
    part_d       = part_q;
    ovf_d        = ovf_q;

    if (rx_take) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0:    part_d[7:0]   = rx_byte_i;
        2'd1:    part_d[15:8]  = rx_byte_i;
        2'd2:    part_d[23:16] = rx_byte_i;
        default: part_d        = part_q;
      endcase
    end
    if (word_cmpl) begin
      words_rcvd_d = words_rcvd_q + LEN_W'(1);
      if (!push) ovf_d = 1'b1;
    end
    if (dma_grant) begin
      words_done_d = words_done_q + LEN_W'(1);
    end

    case (state_q)
      StActive: if (words_rcvd_q == len_q) state_d = StDrain;
      StDrain:  if (fifo_empty) state_d = StDone;
      default:  state_d = state_q;
    endcase

    // Re-arm from any state; a grant in this cycle still reaches memory but is not counted.
    if (cfg_we_i) begin
      words_rcvd_d = '0;
      words_done_d = '0;
      byte_cnt_d   = '0;
      part_d       = '0;
      ovf_d        = 1'b0;
      state_d      = (cfg_len_i != '0) ? StActive : StDone;
    end

    irq_d = (state_d == StDone) && ((state_q != StDone) || cfg_we_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      base_q       <= '0;
      len_q        <= '0;
      words_rcvd_q <= '0;
      words_done_q <= '0;
      byte_cnt_q   <= '0;
      part_q       <= '0;
      ovf_q        <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_rcvd_q <= words_rcvd_d;
      words_done_q <= words_done_d;
      byte_cnt_q   <= byte_cnt_d;
      part_q       <= part_d;
      ovf_q        <= ovf_d;
      irq_q        <= irq_d;
      if (cfg_we_i) begin
        base_q <= cfg_base_i & ~32'h3;
        len_q  <= cfg_len_i;
      end
    end
  end

`ifdef DMEM_DMA_CSUM_EN
  logic [31:0] csum_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csum_q <= '0;
    end else if (cfg_we_i) begin
      csum_q <= '0;
    end else if (dma_grant) begin
      csum_q <= csum_q + fifo_head;
    end
  end

  assign csum_o = csum_q;
`endif

  assign busy_o       = dma_active;
  assign done_o       = (state_q == StDone);
  assign ovf_o        = ovf_q;
  assign irq_o        = irq_q;
  assign words_done_o = words_done_q;

endmodule

// File: tb/tb_dmem_dma_arbiter.sv
// Scoreboard bench for dmem_dma_arbiter: expected memory accesses are queued, a monitor checks them.
module tb_dmem_dma_arbiter;

  localparam int unsigned LEN_W = 16;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rx_valid = 1'b0;
  logic [7:0]       rx_byte = '0;
  logic             cfg_we = 1'b0;
  logic [31:0]      cfg_base = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             busy, done, ovf, irq;
  logic [LEN_W-1:0] words_done;
`ifdef DMEM_DMA_CSUM_EN
  logic [31:0]      csum;
`endif

  int  total = 0;
  int  bad = 0;
  wr_t wr_q[$];
  logic [31:0] rd_q[$];

  dmem_dma_arbiter_if cpu_bus ();
  dmem_dma_arbiter_if mem_bus ();

  dmem_dma_arbiter #(
    .FIFO_DEPTH (4),
    .LEN_W      (LEN_W)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cpu_bus      (cpu_bus),
    .mem_bus      (mem_bus),
    .rx_valid_i   (rx_valid),
    .rx_byte_i    (rx_byte),
    .cfg_we_i     (cfg_we),
    .cfg_base_i   (cfg_base),
    .cfg_len_i    (cfg_len),
    .busy_o       (busy),
    .done_o       (done),
    .ovf_o        (ovf),
    .irq_o        (irq),
    .words_done_o (words_done)
`ifdef DMEM_DMA_CSUM_EN
    ,
    .csum_o       (csum)
`endif
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] mkword(logic [7:0] start, int n);
    logic [7:0] b0, b1, b2, b3;
    b0 = start + 8'(4 * n);
    b1 = b0 + 8'd1;
    b2 = b0 + 8'd2;
    b3 = b0 + 8'd3;
    return {b3, b2, b1, b0};
  endfunction

  // Monitor: every memory-side access must match the head of its expectation queue.
  always @(negedge clk) begin
    if (mem_bus.wr === 1'b1) begin
      if (wr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %h data %h expected none",
                 mem_bus.addr, mem_bus.wdata);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        chk("wr_addr", mem_bus.addr, e.a);
        chk("wr_data", mem_bus.wdata, e.d);
      end
    end
    if (mem_bus.rd === 1'b1) begin
      if (rd_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_read: got addr %h expected none", mem_bus.addr);
      end else begin
        chk("rd_addr", mem_bus.addr, rd_q.pop_front());
      end
    end
  end

  // One clock: queue any CPU memory access being presented, then step past the edge.
  task automatic cyc();
    if (cpu_bus.rd && !cpu_bus.addr[30]) rd_q.push_back(cpu_bus.addr);
    if (cpu_bus.wr && !cpu_bus.addr[30]) wr_q.push_back('{a: cpu_bus.addr, d: cpu_bus.wdata});
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [31:0] base, input int len);
    cfg_we   = 1'b1;
    cfg_base = base;
    cfg_len  = LEN_W'(len);
    cyc();
    cfg_we   = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_byte  = start + 8'(i);
      cyc();
    end
    rx_valid = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output int irqs);
    int n;
    irqs = 0;
    n = 0;
    while (!done && n < budget) begin
      cyc();
      n++;
      if (irq) irqs++;
    end
    chk("done_reached", 32'(done), 32'd1);
    cyc();
    if (irq) irqs++;
  endtask

  task automatic cpu_idle();
    cpu_bus.rd    = 1'b0;
    cpu_bus.wr    = 1'b0;
    cpu_bus.addr  = '0;
    cpu_bus.wdata = '0;
  endtask

  initial begin
    int irqs;
    cpu_idle();
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_words_done", 32'(words_done), 32'd0);
    chk("rst_mem_addr", mem_bus.addr, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();

    // Bytes in IDLE are ignored.
    send_bytes(8'hE0, 4);
    cyc();
    chk("idle_rx_busy", 32'(busy), 32'd0);

    // Basic transfer, CPU idle.
    cfg(32'h100, 2);
    wr_q.push_back('{a: 32'h100, d: 32'h44332211});
    wr_q.push_back('{a: 32'h104, d: 32'h88776655});
    chk("t1_busy", 32'(busy), 32'd1);
    send_bytes(8'h11, 1); send_bytes(8'h22, 1); send_bytes(8'h33, 1); send_bytes(8'h44, 1);
    send_bytes(8'h55, 1); send_bytes(8'h66, 1); send_bytes(8'h77, 1); send_bytes(8'h88, 1);
    run_until_done(20, irqs);
    chk("t1_irq_count", 32'(irqs), 32'd1);
    chk("t1_words_done", 32'(words_done), 32'd2);
    chk("t1_ovf", 32'(ovf), 32'd0);

    // CPU load wins every cycle; DMA writes the first cycle the CPU lets go.
    cfg(32'h300, 1);
    wr_q.push_back('{a: 32'h300, d: mkword(8'h20, 0)});
    cpu_bus.rd   = 1'b1;
    cpu_bus.addr = 32'h200;
    send_bytes(8'h20, 4);
    cyc();
    chk("t2_cpu_wins_wr", 32'(mem_bus.wr), 32'd0);
    chk("t2_cpu_wins_addr", mem_bus.addr, 32'h200);
    cyc();
    cpu_idle();
    #1;
    chk("t2_dma_after_cpu", 32'(mem_bus.wr), 32'd1);
    chk("t2_dma_addr", mem_bus.addr, 32'h300);
    run_until_done(20, irqs);
    chk("t2_irq_count", 32'(irqs), 32'd1);
    chk("t2_words_done", 32'(words_done), 32'd1);

    // CPU store to DataMem passes through; peripheral stores do not block DMA.
    cpu_bus.wr    = 1'b1;
    cpu_bus.addr  = 32'h80;
    cpu_bus.wdata = 32'h12345678;
    cyc();
    cpu_bus.addr  = 32'h4000_0010;
    cpu_bus.wdata = 32'hDEAD_BEEF;
    cfg(32'h400, 1);
    wr_q.push_back('{a: 32'h400, d: mkword(8'h50, 0)});
    send_bytes(8'h50, 4);
    chk("t3_periph_grant", 32'(mem_bus.wr), 32'd1);
    chk("t3_periph_addr", mem_bus.addr, 32'h400);
    cyc();
    cpu_idle();
    run_until_done(20, irqs);
    chk("t3_words_done", 32'(words_done), 32'd1);

    // CPU starves DMA: 4 words queue, 2 drop, transfer waits for all 8 words.
    cfg(32'h1000, 8);
    cpu_bus.rd   = 1'b1;
    cpu_bus.addr = 32'h200;
    send_bytes(8'h30, 24);
    chk("t4_ovf", 32'(ovf), 32'd1);
    for (int i = 0; i < 4; i++) wr_q.push_back('{a: 32'h1000 + 32'(4 * i), d: mkword(8'h30, i)});
    cpu_idle();
    for (int i = 0; i < 8; i++) cyc();
    chk("t4_words_done_mid", 32'(words_done), 32'd4);
    chk("t4_still_busy", 32'(busy), 32'd1);
    chk("t4_not_done", 32'(done), 32'd0);
    wr_q.push_back('{a: 32'h1010, d: mkword(8'h30, 6)});
    wr_q.push_back('{a: 32'h1014, d: mkword(8'h30, 7)});
    send_bytes(8'h30 + 8'd24, 8);
    run_until_done(20, irqs);
    chk("t4_irq_count", 32'(irqs), 32'd1);
    chk("t4_words_done", 32'(words_done), 32'd6);
    chk("t4_ovf_sticky", 32'(ovf), 32'd1);

    // Re-arm mid-transfer with a partial word: FIFO flushed, counters cleared, new base.
    cfg(32'h2000, 8);
    cpu_bus.rd   = 1'b1;
    cpu_bus.addr = 32'h200;
    send_bytes(8'h60, 22);
    chk("t5_ovf_before", 32'(ovf), 32'd1);
    cfg(32'h3001, 1);
    chk("t5_ovf_cleared", 32'(ovf), 32'd0);
    chk("t5_words_done_cleared", 32'(words_done), 32'd0);
    chk("t5_done_cleared", 32'(done), 32'd0);
    chk("t5_busy", 32'(busy), 32'd1);
    cpu_idle();
    for (int i = 0; i < 3; i++) cyc();
    chk("t5_flushed", 32'(words_done), 32'd0);
    wr_q.push_back('{a: 32'h3000, d: 32'hA3A2A1A0});
    send_bytes(8'hA0, 4);
    run_until_done(20, irqs);
    chk("t5_irq_count", 32'(irqs), 32'd1);
    chk("t5_words_done", 32'(words_done), 32'd1);

    // Zero length: straight to DONE with an irq pulse and no writes.
    cfg(32'h4000, 0);
    chk("t6_len0_done", 32'(done), 32'd1);
    chk("t6_len0_irq", 32'(irq), 32'd1);
    cyc();
    chk("t6_len0_irq_pulse", 32'(irq), 32'd0);

    // Asynchronous reset while draining.
    cfg(32'h5000, 1);
    cpu_bus.rd   = 1'b1;
    cpu_bus.addr = 32'h200;
    send_bytes(8'hC0, 4);
    cyc();
    chk("t6_drain_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    cpu_idle();
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_words_done", 32'(words_done), 32'd0);
    chk("t6_rst_mem_wr", 32'(mem_bus.wr), 32'd0);
    chk("t6_rst_mem_wdata", mem_bus.wdata, 32'd0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    chk("t6_idle_after_rst", 32'(busy), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
